// File: rtl/demux_16bit_block_loader_pkg.sv
// demux_16bit_block_loader_pkg: shared defaults, channel state encoding and select polarity
package demux_16bit_block_loader_pkg;
   localparam int WORD_W_DEF = 16;
   localparam int WORDS_DEF  = 8;
   localparam logic ST_FILL = 1'b0;
   localparam logic ST_FULL = 1'b1;
   localparam logic SEL_CH0 = 1'b1;
   localparam logic SEL_CH1 = 1'b0;
endpackage

// File: rtl/demux_16bit_block_loader_accum.sv
// block_accumulator_16bit: one channel's word-to-block assembly with valid/ready output
module block_accumulator_16bit
   import demux_16bit_block_loader_pkg::*;
#(
   parameter int WORD_W = WORD_W_DEF,
   parameter int WORDS = WORDS_DEF,
   localparam int BLOCK_W = WORD_W * WORDS,
   localparam int CW = $clog2(WORDS + 1)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               wr,
   input  logic [WORD_W-1:0]  word,
   input  logic               flush,
   input  logic               ready,
   output logic [BLOCK_W-1:0] data,
   output logic               valid,
   output logic [CW-1:0]      count,
   output logic               filling
);
   localparam logic [CW-1:0] LAST = CW'(WORDS - 1);
   logic state;
   assign valid   = state == ST_FULL;
   assign filling = state == ST_FILL;
   // FULL holds the block until drained; FILL writes word k to slot k, MSB first
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_FILL;
         count <= '0;
         data  <= '0;
      end else if (state == ST_FULL) begin
         if (ready) begin
            state <= ST_FILL;
            count <= '0;
         end
      end else if (flush) begin
         count <= '0;
      end else if (wr) begin
         for (int k = 0; k < WORDS; k++)
            if (count == CW'(k)) data[BLOCK_W-1-k*WORD_W -: WORD_W] <= word;
         count <= count + CW'(1);
         if (count == LAST) state <= ST_FULL;
      end
   end
endmodule

// File: rtl/demux_16bit_block_loader.sv
// demux_16bit_block_loader: steers a 16-bit word stream into two block-assembling channels
module demux_16bit_block_loader
   import demux_16bit_block_loader_pkg::*;
#(
   parameter int WORD_W = WORD_W_DEF,
   parameter int WORDS = WORDS_DEF,
   localparam int BLOCK_W = WORD_W * WORDS,
   localparam int CW = $clog2(WORDS + 1)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [WORD_W-1:0]  in_data,
   input  logic               in_sel,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               flush,
   output logic [BLOCK_W-1:0] ch0_data,
   output logic               ch0_valid,
   input  logic               ch0_ready,
   output logic [BLOCK_W-1:0] ch1_data,
   output logic               ch1_valid,
   input  logic               ch1_ready,
   output logic [CW-1:0]      ch0_count,
   output logic [CW-1:0]      ch1_count
);
   logic fill0, fill1, accept;
   assign in_ready = rst_n & ~flush & (in_sel == SEL_CH0 ? fill0 : fill1);
   assign accept   = in_valid & in_ready;

   block_accumulator_16bit #(.WORD_W(WORD_W), .WORDS(WORDS)) u_ch0 (
      .clk(clk), .rst_n(rst_n), .wr(accept & (in_sel == SEL_CH0)), .word(in_data),
      .flush(flush), .ready(ch0_ready), .data(ch0_data), .valid(ch0_valid),
      .count(ch0_count), .filling(fill0)
   );

   block_accumulator_16bit #(.WORD_W(WORD_W), .WORDS(WORDS)) u_ch1 (
      .clk(clk), .rst_n(rst_n), .wr(accept & (in_sel == SEL_CH1)), .word(in_data),
      .flush(flush), .ready(ch1_ready), .data(ch1_data), .valid(ch1_valid),
      .count(ch1_count), .filling(fill1)
   );
endmodule

// File: tb/tb_demux_16bit_block_loader.sv
// tb_demux_16bit_block_loader: directed tables, corner sequences and random traffic against a word-list model
module tb_demux_16bit_block_loader;
   localparam int WN = 8;
   logic clk = 1'b0, rst_n = 1'b0;
   logic [15:0] in_data = '0;
   logic in_sel = 1'b0, in_valid = 1'b0, flush = 1'b0, ch0_ready = 1'b0, ch1_ready = 1'b0;
   logic in_ready, ch0_valid, ch1_valid;
   logic [127:0] ch0_data, ch1_data;
   logic [3:0] ch0_count, ch1_count;
   int tests = 0, fails = 0;
   int mcnt[2];
   logic [15:0] mw[2][WN];

   typedef struct {
      logic        sel;
      logic [15:0] d;
      logic [3:0]  exp_cnt;
      logic        exp_valid;
   } vec_t;
   vec_t tbl[8];

   demux_16bit_block_loader dut (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
      .in_ready(in_ready), .flush(flush), .ch0_data(ch0_data), .ch0_valid(ch0_valid),
      .ch0_ready(ch0_ready), .ch1_data(ch1_data), .ch1_valid(ch1_valid), .ch1_ready(ch1_ready),
      .ch0_count(ch0_count), .ch1_count(ch1_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   function automatic logic [127:0] mblk(input int c);
      logic [127:0] b = '0;
      for (int k = 0; k < WN; k++) b = {b[111:0], mw[c][k]};
      return b;
   endfunction

   function automatic bit mrdy();
      int c = in_sel ? 0 : 1;
      return rst_n && !flush && mcnt[c] < WN;
   endfunction

   task automatic model_reset();
      for (int c = 0; c < 2; c++) begin
         mcnt[c] = 0;
         for (int k = 0; k < WN; k++) mw[c][k] = '0;
      end
   endtask

   // check everything against the model, then advance both one clock edge
   task automatic tick();
      bit acc;
      int tgt;
      #1;
      chk("in_ready", 128'(in_ready), 128'(mrdy()));
      chk("ch0_valid", 128'(ch0_valid), 128'(mcnt[0] == WN));
      chk("ch1_valid", 128'(ch1_valid), 128'(mcnt[1] == WN));
      chk("ch0_count", 128'(ch0_count), 128'(mcnt[0]));
      chk("ch1_count", 128'(ch1_count), 128'(mcnt[1]));
      chk("ch0_data", ch0_data, mblk(0));
      chk("ch1_data", ch1_data, mblk(1));
      acc = in_valid && mrdy();
      tgt = in_sel ? 0 : 1;
      for (int c = 0; c < 2; c++) begin
         if (mcnt[c] == WN) begin
            if (c == 0 ? ch0_ready : ch1_ready) mcnt[c] = 0;
         end else if (flush) mcnt[c] = 0;
         else if (acc && tgt == c) begin
            mw[c][mcnt[c]] = in_data;
            mcnt[c]++;
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic send(input logic s, input logic [15:0] d);
      in_sel = s;
      in_data = d;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   localparam logic [127:0] BLK_A = 128'h00112233445566778899AABBCCDDEEFF;

   initial begin
      tbl[0] = '{1'b1, 16'h0011, 4'd1, 1'b0};
      tbl[1] = '{1'b1, 16'h2233, 4'd2, 1'b0};
      tbl[2] = '{1'b1, 16'h4455, 4'd3, 1'b0};
      tbl[3] = '{1'b1, 16'h6677, 4'd4, 1'b0};
      tbl[4] = '{1'b1, 16'h8899, 4'd5, 1'b0};
      tbl[5] = '{1'b1, 16'hAABB, 4'd6, 1'b0};
      tbl[6] = '{1'b1, 16'hCCDD, 4'd7, 1'b0};
      tbl[7] = '{1'b1, 16'hEEFF, 4'd8, 1'b1};
      model_reset();
      in_sel = 1'b1;
      @(negedge clk);
      #1 chk("in_ready_in_reset", 128'(in_ready), 128'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_in_ready", 128'(in_ready), 128'd1);
      chk("rst_ch0_data", ch0_data, 128'd0);
      chk("rst_ch1_data", ch1_data, 128'd0);
      chk("rst_valids", {ch0_valid, ch1_valid}, 128'd0);
      chk("rst_counts", {ch0_count, ch1_count}, 128'd0);

      for (int i = 0; i < 8; i++) begin
         send(tbl[i].sel, tbl[i].d);
         chk("tbl_ch0_count", 128'(ch0_count), 128'(tbl[i].exp_cnt));
         chk("tbl_ch0_valid", 128'(ch0_valid), 128'(tbl[i].exp_valid));
      end
      chk("load_ch0_data", ch0_data, BLK_A);
      chk("load_ch1_count", 128'(ch1_count), 128'd0);

      in_sel = 1'b1;
      in_data = 16'hDEAD;
      in_valid = 1'b1;
      #1 chk("bp_in_ready", 128'(in_ready), 128'd0);
      tick();
      chk("bp_ch0_data", ch0_data, BLK_A);
      send(1'b0, 16'h1234);
      chk("bp_ch1_count", 128'(ch1_count), 128'd1);

      send(1'b0, 16'h2345);
      send(1'b0, 16'h3456);
      chk("pre_flush_ch1_count", 128'(ch1_count), 128'd3);
      flush = 1'b1;
      in_sel = 1'b0;
      in_data = 16'h7777;
      in_valid = 1'b1;
      #1 chk("flush_in_ready", 128'(in_ready), 128'd0);
      tick();
      flush = 1'b0;
      in_valid = 1'b0;
      chk("flush_ch1_count", 128'(ch1_count), 128'd0);
      chk("flush_ch0_valid", 128'(ch0_valid), 128'd1);
      chk("flush_ch0_data", ch0_data, BLK_A);

      ch0_ready = 1'b1;
      in_sel = 1'b1;
      in_data = 16'h5555;
      in_valid = 1'b1;
      #1 chk("drain_in_ready", 128'(in_ready), 128'd0);
      tick();
      ch0_ready = 1'b0;
      chk("drain_ch0_valid", 128'(ch0_valid), 128'd0);
      chk("drain_ch0_count", 128'(ch0_count), 128'd0);
      tick();
      in_valid = 1'b0;
      chk("refill_ch0_count", 128'(ch0_count), 128'd1);
      flush = 1'b1;
      tick();
      flush = 1'b0;

      for (int i = 0; i < 16; i++) begin
         send(i % 2 == 0, i % 2 == 0 ? 16'(i / 2) : 16'(16'h0100 + i / 2));
         if (i == 14) chk("il_ch0_first", {ch0_valid, ch1_valid}, 128'b10);
         if (i == 15) chk("il_both", {ch0_valid, ch1_valid}, 128'b11);
      end
      chk("il_ch0_data", ch0_data, 128'h0000000100020003000400050006_0007);
      chk("il_ch1_data", ch1_data, 128'h0100010101020103010401050106_0107);

      for (int i = 0; i < 600; i++) begin
         in_sel = 1'($urandom);
         in_data = 16'($urandom);
         in_valid = $urandom_range(3) != 0;
         ch0_ready = $urandom_range(3) == 0;
         ch1_ready = $urandom_range(3) == 0;
         flush = $urandom_range(15) == 0;
         tick();
      end
      in_valid = 1'b0;
      flush = 1'b0;
      ch0_ready = 1'b0;
      ch1_ready = 1'b0;

      rst_n = 1'b0;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) send(1'b1, 16'(16'hA000 + i));
      chk("pre_arst_ch0_count", 128'(ch0_count), 128'd5);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_ch0_count", 128'(ch0_count), 128'd0);
      chk("arst_ch0_valid", 128'(ch0_valid), 128'd0);
      chk("arst_ch0_data", ch0_data, 128'd0);
      chk("arst_in_ready", 128'(in_ready), 128'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
